gaussian_window_ctrl: RTL and testbench

- Frame sequencer and 3x3 window generator that feeds the 3x3 Gaussian blur stage.
- Accepts a raster-order 8-bit pixel stream, buffers two previous lines, and emits one 72-bit window per interior pixel.
- Counts the blurred results returned by the filter and signals frame completion.
- Sits between the pixel source and the Gaussian filter; the filter's o_data/o_valid go downstream, and its o_valid also loops back here.

---
 rtl/gaussian_window_ctrl.sv | 122 ++++++++++++
 tb/tb_gaussian_window_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_window_ctrl.sv
// Frame sequencer and 3x3 window generator in front of the Gaussian blur.
// Buffers two lines, emits one packed window per interior pixel, counts results.
module gaussian_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10,
    parameter int RW    = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_start,
    input  logic [7:0]  i_pixel,
    input  logic        i_pixel_valid,
    output logic        o_ready,
    output logic [71:0] o_window,
    output logic        o_window_valid,
    input  logic        i_filt_valid,
    output logic        o_busy,
    output logic        o_frame_done
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    localparam int NW = CW + RW;
    localparam logic [NW-1:0] TGT = NW'((IMG_W - 2) * (IMG_H - 2));

    state_t          state, state_nxt;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [NW-1:0]   res_cnt, res_cnt_nxt;
    logic [7:0]      lb0 [IMG_W];
    logic [7:0]      lb1 [IMG_W];
    logic [23:0]     wc0, wc1, wc2;
    logic [71:0]     win_nxt;
    logic            accept, last_px, emit, counting;

    assign accept   = (state == STREAM) && i_pixel_valid;
    assign last_px  = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign counting = (state == STREAM) || (state == DRAIN);

    // Column byte r holds window row r; row 0 is the oldest line.
    assign wc2 = {i_pixel, lb1[col], lb0[col]};

    always_comb begin
        win_nxt = '0;
        for (int r = 0; r < 3; r++) begin
            win_nxt[(3*r)*8   +: 8] = wc0[r*8 +: 8];
            win_nxt[(3*r+1)*8 +: 8] = wc1[r*8 +: 8];
            win_nxt[(3*r+2)*8 +: 8] = wc2[r*8 +: 8];
        end
    end

    always_comb begin
        res_cnt_nxt = res_cnt;
        if (counting && i_filt_valid && (res_cnt != TGT))
            res_cnt_nxt = res_cnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Lookahead on the count so DONE follows the final result directly.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (i_start) state_nxt = STREAM;
            STREAM: if (accept && last_px) state_nxt = DRAIN;
            DRAIN:  if (res_cnt_nxt == TGT) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready      = (state == STREAM);
        o_busy       = counting;
        o_frame_done = (state == DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            col            <= '0;
            row            <= '0;
            res_cnt        <= '0;
            wc0            <= '0;
            wc1            <= '0;
            o_window       <= '0;
            o_window_valid <= 1'b0;
        end else begin
            o_window_valid <= emit;
            if (state == IDLE && i_start) begin
                col     <= '0;
                row     <= '0;
                res_cnt <= '0;
            end else begin
                res_cnt <= res_cnt_nxt;
                if (accept) begin
                    wc0 <= wc1;
                    wc1 <= wc2;
                    if (col == CW'(IMG_W - 1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                    if (emit) o_window <= win_nxt;
                end
            end
        end
    end

    // Line buffers are deliberately not reset; the row gate hides stale data.
    always_ff @(posedge CLK) begin
        if (accept) begin
            lb0[col] <= lb1[col];
            lb1[col] <= i_pixel;
        end
    end

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Bench for gaussian_window_ctrl on a 4x4 frame.
// Expected windows come from a table and flow through a scoreboard queue.
module tb_gaussian_window_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_pixel = '0;
    logic        i_pixel_valid = 1'b0;
    logic        o_ready;
    logic [71:0] o_window;
    logic        o_window_valid;
    logic        i_filt_valid;
    logic        o_busy;
    logic        o_frame_done;
    logic [3:0]  fpipe;
    logic        spur = 1'b0;

    always #5 clk = ~clk;

    gaussian_window_ctrl #(
        .IMG_W(4), .IMG_H(4), .CW(2), .RW(2)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .i_start(i_start),
        .i_pixel(i_pixel),
        .i_pixel_valid(i_pixel_valid),
        .o_ready(o_ready),
        .o_window(o_window),
        .o_window_valid(o_window_valid),
        .i_filt_valid(i_filt_valid),
        .o_busy(o_busy),
        .o_frame_done(o_frame_done)
    );

    // Filter model: fixed 4-cycle latency from window to result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fpipe <= '0;
        else        fpipe <= {fpipe[2:0], o_window_valid};
    end
    assign i_filt_valid = fpipe[3] | spur;

    typedef struct {
        int          row;
        int          col;
        logic [71:0] win;
    } vec_t;

    typedef struct {
        bit gaps;
        bit mid_start;
        bit spur_idle;
        bit pre_abort;
    } scen_t;

    typedef struct {
        logic [71:0] win;
        int          cyc;
        int          idx;
    } exp_t;

    vec_t  tbl [4];
    scen_t scen [4];
    exp_t  sbq [$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    nwin = 0;
    int    np = 0;
    int    last_pulse = 0;

    function automatic logic [7:0] gauss(input logic [71:0] w);
        int wt [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int s = 0;
        for (int k = 0; k < 9; k++) s += wt[k] * int'(w[k*8 +: 8]);
        return 8'(s / 16);
    endfunction

    task automatic chk(input string nm, input logic [71:0] got,
                       input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // One cycle: advance to the falling edge, then run the output monitor.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (i_filt_valid) begin
            np++;
            last_pulse = cyc;
        end
        if (rst_n && o_window_valid) begin
            nwin++;
            chk("window_expected", 72'(sbq.size() != 0), 72'(1));
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("window_data", o_window, e.win);
                chk("window_latency", 72'(cyc - e.cyc), 72'(1));
                if (e.idx == 0)
                    chk("filter_first", 72'(gauss(o_window)), 72'(8'h11));
            end
        end
    endtask

    task automatic run_frame(input scen_t s);
        int  k = 0;
        bit  got = 0;
        nwin = 0;
        if (s.spur_idle) begin
            spur = 1'b1;
            tick();
            spur = 1'b0;
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        np = 0;
        chk("start_busy_ready", 72'({o_busy, o_ready}), 72'(2'b11));
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                i_pixel       = 8'(16 * r + c);
                i_pixel_valid = 1'b1;
                if (s.mid_start && r == 1 && c == 1) i_start = 1'b1;
                if (k < 4 && tbl[k].row == r && tbl[k].col == c) begin
                    sbq.push_back('{tbl[k].win, cyc, k});
                    k++;
                end
                tick();
                i_start = 1'b0;
                if (s.gaps) begin
                    i_pixel_valid = 1'b0;
                    i_pixel       = 8'hee;
                    tick();
                end
            end
        end
        // Junk kept valid while draining must be dropped.
        i_pixel       = 8'h5a;
        i_pixel_valid = 1'b1;
        chk("ready_drop", 72'(o_ready), 72'(0));
        for (int t = 0; t < 60 && !got; t++) begin
            if (o_frame_done) begin
                got = 1;
                chk("result_count", 72'(np), 72'(4));
                chk("done_timing", 72'(cyc - last_pulse), 72'(1));
                chk("busy_at_done", 72'(o_busy), 72'(0));
                i_start = 1'b1;
                tick();
                i_start = 1'b0;
                chk("done_single_no_restart",
                    72'({o_frame_done, o_busy, o_ready}), 72'(0));
            end else begin
                tick();
            end
        end
        chk("frame_done_seen", 72'(got), 72'(1));
        i_pixel_valid = 1'b0;
        chk("window_count", 72'(nwin), 72'(4));
        chk("scoreboard_empty", 72'(sbq.size()), 72'(0));
    endtask

    // Stream rows 0-1 of a different frame, then reset asynchronously.
    task automatic abort_frame();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                i_pixel       = 8'(8'h80 + 16 * r + c);
                i_pixel_valid = 1'b1;
                tick();
            end
        end
        i_pixel_valid = 1'b0;
        chk("busy_before_rst", 72'({o_busy, o_ready}), 72'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs",
            72'({o_ready, o_busy, o_window_valid, o_frame_done}), 72'(0));
        chk("async_rst_window", o_window, 72'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        tbl[0] = '{2, 2, 72'h22_21_20_12_11_10_02_01_00};
        tbl[1] = '{2, 3, 72'h23_22_21_13_12_11_03_02_01};
        tbl[2] = '{3, 2, 72'h32_31_30_22_21_20_12_11_10};
        tbl[3] = '{3, 3, 72'h33_32_31_23_22_21_13_12_11};
        scen[0] = '{0, 0, 0, 0};
        scen[1] = '{1, 0, 0, 0};
        scen[2] = '{0, 1, 1, 0};
        scen[3] = '{0, 0, 0, 1};

        tick();
        tick();
        chk("reset_outputs",
            72'({o_ready, o_busy, o_window_valid, o_frame_done}), 72'(0));
        chk("reset_window", o_window, 72'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            i_pixel       = 8'($urandom);
            i_pixel_valid = 1'b1;
            tick();
            chk("idle_outputs",
                72'({o_ready, o_busy, o_window_valid, o_frame_done}), 72'(0));
        end
        i_pixel_valid = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            if (scen[i].pre_abort) abort_frame();
            run_frame(scen[i]);
            tick();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
